// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

   localparam int BE_W  = 4;
   localparam int REG_W = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and legality checks.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic            is_store,
   input  logic [1:0]      lane,
   input  logic [31:0]     store_data,
   input  logic [31:0]     bus_rdata,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata,
   output logic [31:0]     load_value,
   output logic            misaligned,
   output logic            illegal
);

   function automatic logic [31:0] sext8(input logic signed [7:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   logic [31:0] shifted;

   assign shifted = bus_rdata >> {lane, 3'b000};

   assign misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                       ((funct3[1:0] == 2'b10) && (lane != 2'b00));

   always_comb begin
      be      = '0;
      wdata   = store_data;
      illegal = 1'b0;
      if (is_store) begin
         case (funct3)
            F3_SB: begin
               be    = 4'b0001 << lane;
               wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
               be    = 4'b0011 << lane;
               wdata = {2{store_data[15:0]}};
            end
            F3_SW:   be = 4'b1111;
            default: illegal = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
            default:                             illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      load_value = bus_rdata;
      case (funct3)
         F3_LB:   load_value = sext8(shifted[7:0]);
         F3_LBU:  load_value = {24'h0, shifted[7:0]};
         F3_LH:   load_value = sext16(shifted[15:0]);
         F3_LHU:  load_value = {16'h0, shifted[15:0]};
         default: load_value = bus_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a single-outstanding req/ack bus.
// Optional bus timeout when LSU_TIMEOUT_EN is defined.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             mem_read_enable,
   input  logic             mem_write_enable,
   input  logic [2:0]       load_operation,
   input  logic [2:0]       store_operation,
   input  logic [31:0]      addr,
   input  logic [31:0]      store_data,
   input  logic [REG_W-1:0] rd_in,
   output logic             resp_valid,
   output logic             resp_err,
   output logic [31:0]      load_data,
   output logic [REG_W-1:0] rd_out,
   output logic             bus_req,
   output logic             bus_we,
   output logic [31:0]      bus_addr,
   output logic [31:0]      bus_wdata,
   output logic [BE_W-1:0]  bus_be,
   input  logic             bus_ack,
   input  logic [31:0]      bus_rdata
);

   lsu_state_t state, next_state;

   logic             req_we;
   logic [2:0]       req_funct3;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [BE_W-1:0]  req_be;
   logic [REG_W-1:0] req_rd;
   logic             req_err;
   logic [31:0]      resp_data;

   logic             sel_store;
   logic [2:0]       sel_funct3;
   logic [1:0]       sel_lane;
   logic [BE_W-1:0]  align_be;
   logic [31:0]      align_wdata;
   logic [31:0]      align_load;
   logic             misaligned;
   logic             illegal;
   logic             accept;
   logic             req_bad;
   logic             timeout;

   // The aligner checks the incoming request in IDLE and extracts load data from the held request in BUS.
   assign sel_store  = (state == IDLE) ? mem_write_enable : req_we;
   assign sel_funct3 = (state == IDLE) ? (mem_write_enable ? store_operation : load_operation)
                                       : req_funct3;
   assign sel_lane   = (state == IDLE) ? addr[1:0] : req_addr[1:0];

   lsu_align u_align (
      .funct3     (sel_funct3),
      .is_store   (sel_store),
      .lane       (sel_lane),
      .store_data (store_data),
      .bus_rdata  (bus_rdata),
      .be         (align_be),
      .wdata      (align_wdata),
      .load_value (align_load),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   assign accept  = req_valid && (state == IDLE);
   assign req_bad = (mem_read_enable == mem_write_enable) || illegal || misaligned;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (state != BUS)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (state == BUS) && !bus_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = req_bad ? RESP : BUS;
         BUS:     if (bus_ack || timeout) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request and response holding registers; outputs are gated by state so these need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_we     <= mem_write_enable;
         req_funct3 <= sel_funct3;
         req_addr   <= addr;
         req_wdata  <= align_wdata;
         req_be     <= mem_write_enable ? align_be : '0;
         req_rd     <= (mem_write_enable || req_bad) ? '0 : rd_in;
         req_err    <= req_bad;
         resp_data  <= '0;
      end else if ((state == BUS) && bus_ack) begin
         resp_data  <= req_we ? '0 : align_load;
      end else if (timeout) begin
         req_err    <= 1'b1;
         req_rd     <= '0;
      end
   end

   assign req_ready  = (state == IDLE);
   assign bus_req    = (state == BUS);
   assign bus_we     = bus_req && req_we;
   assign bus_addr   = bus_req ? {req_addr[31:2], 2'b00} : '0;
   assign bus_wdata  = bus_req ? req_wdata : '0;
   assign bus_be     = bus_req ? req_be : '0;
   assign resp_valid = (state == RESP);
   assign resp_err   = resp_valid && req_err;
   assign load_data  = resp_valid ? resp_data : '0;
   assign rd_out     = resp_valid ? req_rd : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases, then randomized loads/stores.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [2:0]  load_operation;
   logic [2:0]  store_operation;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] load_data;
   logic [4:0]  rd_out;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .load_operation   (load_operation),
      .store_operation  (store_operation),
      .addr             (addr),
      .store_data       (store_data),
      .rd_in            (rd_in),
      .resp_valid       (resp_valid),
      .resp_err         (resp_err),
      .load_data        (load_data),
      .rd_out           (rd_out),
      .bus_req          (bus_req),
      .bus_we           (bus_we),
      .bus_addr         (bus_addr),
      .bus_wdata        (bus_wdata),
      .bus_be           (bus_be),
      .bus_ack          (bus_ack),
      .bus_rdata        (bus_rdata)
   );

   typedef struct {
      logic        err;
      logic [31:0] data;
      logic [4:0]  rd;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          waits;
   } bus_t;

   resp_t sb_q[$];
   bus_t  bus_q[$];
   int    total = 0;
   int    bad = 0;
   logic [31:0] mem [logic [31:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit ref_err(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (re == we) return 1'b1;
      if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!legal) return 1'b1;
      return (int'(a[1:0]) % acc_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, v;
      int sz, off;
      w = mem_word({a[31:2], 2'b00});
      sz = acc_size(f3);
      off = int'(a[1:0]);
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (!f3[2]) for (int j = 8*sz; j < 32; j++) v[j] = v[8*sz-1];
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] b;
      b = '0;
      for (int i = 0; i < acc_size(f3); i++) b[int'(a[1:0]) + i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % acc_size(f3)) +: 8];
      return w;
   endfunction

   // ---------------- response monitor ----------------
   resp_t mon_r;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && resp_valid) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
            end else begin
               mon_r = sb_q.pop_front();
               check("resp_err", 32'(resp_err), 32'(mon_r.err));
               check("load_data", load_data, mon_r.data);
               check("rd_out", 32'(rd_out), 32'(mon_r.rd));
            end
         end
      end
   end

   // ---------------- bus responder ----------------
   bus_t cur;
   bit   active = 0;
   int   k = 0;
   initial begin
      bus_ack = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (reset || !bus_req) begin
            active = 0;
            if (!reset && $urandom_range(0, 7) == 0) begin
               bus_ack = 1'b1;
               bus_rdata = $urandom;
            end
         end else begin
            if (!active) begin
               if (bus_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_bus_req: got bus_req=1 expected 0 at %0t", $time);
                  cur.we = bus_we; cur.addr = bus_addr; cur.be = bus_be; cur.wdata = bus_wdata; cur.waits = 0;
               end else begin
                  cur = bus_q.pop_front();
               end
               active = 1;
               k = 0;
            end
            check("bus_we", 32'(bus_we), 32'(cur.we));
            check("bus_addr", bus_addr, cur.addr);
            check("bus_be", 32'(bus_be), 32'(cur.be));
            if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
            if (k == cur.waits) begin
               bus_ack = 1'b1;
               bus_rdata = mem_word(cur.addr);
            end
            k++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input int waits, input int exp_lat_in);
      bit    e;
      resp_t r;
      bus_t  b;
      int    lat, exp_lat;
      bit    got;
      e = ref_err(re, we, (we && !re) ? f3 : f3, a);
      r.err  = e;
      r.data = (e || we) ? 32'h0 : ref_load(f3, a);
      r.rd   = (e || we) ? 5'd0 : rd;
      if (!e) begin
         b.we    = we;
         b.addr  = {a[31:2], 2'b00};
         b.be    = we ? ref_be(f3, a) : 4'b0000;
         b.wdata = we ? ref_wdata(f3, sd) : 32'h0;
         b.waits = waits;
         bus_q.push_back(b);
      end
      if (exp_lat_in > 0) begin
         exp_lat = exp_lat_in;
         r.err = 1'b1;
         r.data = 32'h0;
         r.rd = 5'd0;
      end else begin
         exp_lat = e ? 1 : 2 + waits;
      end
      sb_q.push_back(r);
      req_valid = 1'b1;
      mem_read_enable = re;
      mem_write_enable = we;
      load_operation = we ? 3'($urandom) : f3;
      store_operation = we ? f3 : 3'($urandom);
      if (re && we) begin
         load_operation = f3;
         store_operation = f3;
      end
      addr = a;
      store_data = sd;
      rd_in = rd;
      @(negedge clk);
      check("ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      addr = $urandom;
      store_data = $urandom;
      rd_in = 5'($urandom);
      got = 0;
      lat = 0;
      for (int c = 1; c <= 200 && !got; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1;
            lat = c;
         end else begin
            check("ready_busy", 32'(req_ready), 32'd0);
            if (e) check("no_bus_on_err", 32'(bus_req), 32'd0);
         end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);
      check("resp_pulse", 32'(resp_valid), 32'd0);
      check("ready_back", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_mid();
      bus_t b;
      b.we = 1'b0; b.addr = 32'h5000; b.be = 4'b0000; b.wdata = 32'h0; b.waits = 5;
      bus_q.push_back(b);
      req_valid = 1'b1;
      mem_read_enable = 1'b1;
      mem_write_enable = 1'b0;
      load_operation = 3'b010;
      addr = 32'h5000;
      rd_in = 5'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp", 32'(resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_resp", 32'(resp_valid), 32'd0);
         check("post_rst_ready", 32'(req_ready), 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      bit re, we;
      logic [2:0] f3;
      reset = 1'b1;
      req_valid = 1'b0;
      mem_read_enable = 1'b0;
      mem_write_enable = 1'b0;
      load_operation = '0;
      store_operation = '0;
      addr = '0;
      store_data = '0;
      rd_in = '0;
      mem[32'h1000] = 32'h80FF1234;
      mem[32'h2000] = 32'hBEEF0000;
      #1;
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_resp", 32'(resp_valid), 32'd0);
      check("reset_bus_req", 32'(bus_req), 32'd0);
      check("reset_be", 32'(bus_be), 32'd0);
      check("reset_load_data", load_data, 32'd0);
      check("reset_rd", 32'(rd_out), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      do_req(1, 0, 3'b000, 32'h1003, 32'h0, 5'd7, 0, 0);
      do_req(1, 0, 3'b101, 32'h2002, 32'h0, 5'd9, 1, 0);
      do_req(1, 0, 3'b001, 32'h2002, 32'h0, 5'd10, 0, 0);
      do_req(0, 1, 3'b000, 32'h3001, 32'h000000AB, 5'd4, 0, 0);
      do_req(0, 1, 3'b001, 32'h3002, 32'h00001234, 5'd4, 2, 0);
      do_req(1, 0, 3'b010, 32'h4002, 32'h0, 5'd5, 0, 0);
      do_req(0, 1, 3'b001, 32'h4001, 32'h55, 5'd5, 0, 0);
      do_req(1, 1, 3'b010, 32'h4000, 32'h55, 5'd6, 0, 0);
      do_req(0, 0, 3'b010, 32'h4000, 32'h55, 5'd6, 0, 0);
      do_req(1, 0, 3'b011, 32'h4000, 32'h0, 5'd8, 0, 0);
      do_req(1, 0, 3'b010, 32'h6000, 32'h0, 5'd11, 5, 0);
      do_req(0, 1, 3'b010, 32'h6004, 32'hCAFEF00D, 5'd11, 3, 0);
      reset_mid();
`ifdef LSU_TIMEOUT_EN
      do_req(1, 0, 3'b010, 32'h7000, 32'h0, 5'd12, 1000, 9);
      repeat (3) @(posedge clk);
      #1;
`endif

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 15))
            0:       begin re = 1; we = 1; end
            1:       begin re = 0; we = 0; end
            2, 3, 4, 5, 6, 7: begin re = 0; we = 1; end
            default: begin re = 1; we = 0; end
         endcase
         if ($urandom_range(0, 9) == 0) begin
            f3 = 3'($urandom);
         end else if (we && !re) begin
            f3 = 3'($urandom_range(0, 2));
         end else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         do_req(re, we, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 4), 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
